// File: rtl/sort4_stream_framer.sv
// sort4_stream_framer: packs a byte stream into 4-sample frames, sorts each frame and returns max/2nd max/2nd min/min.
module even_odd_merge_sorter (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic [7:0] d,
    output logic [7:0] largest,
    output logic [7:0] second_largest,
    output logic [7:0] second_smallest,
    output logic [7:0] smallest
);
    logic [7:0] lo_ab, hi_ab, lo_cd, hi_cd, mid_lo, mid_hi;
    always_comb begin
        lo_ab           = a < b ? a : b;
        hi_ab           = a < b ? b : a;
        lo_cd           = c < d ? c : d;
        hi_cd           = c < d ? d : c;
        smallest        = lo_ab < lo_cd ? lo_ab : lo_cd;
        mid_lo          = lo_ab < lo_cd ? lo_cd : lo_ab;
        largest         = hi_ab < hi_cd ? hi_cd : hi_ab;
        mid_hi          = hi_ab < hi_cd ? hi_ab : hi_cd;
        second_smallest = mid_lo < mid_hi ? mid_lo : mid_hi;
        second_largest  = mid_lo < mid_hi ? mid_hi : mid_lo;
    end
endmodule

module sort4_stream_framer #(
    parameter logic [7:0] PAD_VAL = 8'h00,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_max,
    output logic [7:0]       out_second_max,
    output logic [7:0]       out_second_min,
    output logic [7:0]       out_min,
    output logic [2:0]       out_count,
    output logic [CNT_W-1:0] frame_cnt
);
    typedef enum logic [1:0] {COLLECT, SORT, OUT} state_t;
    state_t     state;
    logic [1:0] idx;
    logic [7:0] slot [4];
    logic [2:0] count;
    logic [7:0] s_max, s_second_max, s_second_min, s_min;

    assign in_ready = state == COLLECT;

    even_odd_merge_sorter sorter (
        .a(slot[0]), .b(slot[1]), .c(slot[2]), .d(slot[3]),
        .largest(s_max), .second_largest(s_second_max),
        .second_smallest(s_second_min), .smallest(s_min)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= COLLECT;
            idx            <= '0;
            for (int i = 0; i < 4; i++) slot[i] <= '0;
            count          <= '0;
            out_valid      <= 1'b0;
            out_max        <= '0;
            out_second_max <= '0;
            out_second_min <= '0;
            out_min        <= '0;
            out_count      <= '0;
            frame_cnt      <= '0;
        end else begin
            case (state)
                COLLECT: if (in_valid) begin
                    slot[idx] <= in_data;
                    if (idx == 2'd3 || in_last) begin
                        // slots past the closing sample are padded so the sorter always sees 4 values
                        for (int i = 0; i < 4; i++) if (i > int'(idx)) slot[i] <= PAD_VAL;
                        count <= {1'b0, idx} + 3'd1;
                        idx   <= '0;
                        state <= SORT;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                SORT: begin
                    out_max        <= s_max;
                    out_second_max <= s_second_max;
                    out_second_min <= s_second_min;
                    out_min        <= s_min;
                    out_count      <= count;
                    out_valid      <= 1'b1;
                    state          <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    frame_cnt <= frame_cnt + 1'b1;
                    state     <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_sort4_stream_framer.sv
// tb_sort4_stream_framer: randomized and directed checks of the framer against a queue-based sort model.
module tb_sort4_stream_framer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, out_valid, in_ready2, out_valid2;
    logic [7:0] out_max, out_second_max, out_second_min, out_min;
    logic [7:0] mx2, smx2, smn2, mn2;
    logic [2:0] out_count, cnt2;
    logic [15:0] frame_cnt;
    logic [1:0]  frame_cnt2;

    int checks = 0, errors = 0, frames = 0;

    typedef struct {
        logic [7:0] mx, smx, smn, mn;
        logic [2:0] cnt;
    } res_t;
    res_t       exp_q[$];
    logic [7:0] cur[$];

    always #5 clk = ~clk;

    sort4_stream_framer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_second_max(out_second_max), .out_second_min(out_second_min),
        .out_min(out_min), .out_count(out_count), .frame_cnt(frame_cnt)
    );

    // narrow-counter instance sharing the same stimulus, used only for wrap checks
    sort4_stream_framer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .out_max(mx2), .out_second_max(smx2), .out_second_min(smn2),
        .out_min(mn2), .out_count(cnt2), .frame_cnt(frame_cnt2)
    );

    function automatic void model_push(input logic [7:0] d, input logic l);
        int   v[4];
        int   t;
        res_t r;
        cur.push_back(d);
        if (l || cur.size() == 4) begin
            for (int i = 0; i < 4; i++) v[i] = i < cur.size() ? int'(cur[i]) : 0;
            for (int i = 1; i < 4; i++)
                for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
                    t = v[j]; v[j] = v[j-1]; v[j-1] = t;
                end
            r.mn  = 8'(v[0]);
            r.smn = 8'(v[1]);
            r.smx = 8'(v[2]);
            r.mx  = 8'(v[3]);
            r.cnt = 3'(cur.size());
            exp_q.push_back(r);
            cur.delete();
        end
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        #2;
        cur.delete(); exp_q.delete(); frames = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        int n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (!in_ready) begin errors++; $display("FAIL push_wait in_ready=%b required 1", in_ready); end
        in_valid = 1'b1; in_data = d; in_last = l;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        model_push(d, l);
    endtask

    task automatic pop(input int delay);
        res_t r;
        int   n = 0;
        repeat (delay) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (!out_valid) begin errors++; $display("FAIL pop_wait out_valid=%b required 1", out_valid); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL pop_model no expected frame queued");
        end else begin
            r = exp_q.pop_front();
            if ({out_max, out_second_max, out_second_min, out_min, out_count} !== {r.mx, r.smx, r.smn, r.mn, r.cnt}) begin
                errors++;
                $display("FAIL pop_result got %h %h %h %h cnt %0d required %h %h %h %h cnt %0d",
                         out_max, out_second_max, out_second_min, out_min, out_count, r.mx, r.smx, r.smn, r.mn, r.cnt);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        frames++;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_one_cycle out_valid=%b required 0", out_valid); end
        checks++;
        if (frame_cnt !== 16'(frames)) begin errors++; $display("FAIL pop_frame_cnt got %0d required %0d", frame_cnt, frames); end
        checks++;
        if (frame_cnt2 !== 2'(frames)) begin errors++; $display("FAIL pop_frame_cnt2 got %0d required %0d", frame_cnt2, frames % 4); end
    endtask

    task automatic test_reset();
        checks++;
        if ({out_valid, in_ready, frame_cnt, out_max, out_min, out_count} !== {1'b0, 1'b1, 16'd0, 8'd0, 8'd0, 3'd0}) begin
            errors++; $display("FAIL reset_init out_valid=%b in_ready=%b frame_cnt=%0d required 0 1 0", out_valid, in_ready, frame_cnt);
        end
        rst_n = 1'b1;
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        do_reset();
        checks++;
        if ({out_valid, in_ready, frame_cnt} !== {1'b0, 1'b1, 16'd0}) begin
            errors++; $display("FAIL reset_mid out_valid=%b in_ready=%b frame_cnt=%0d required 0 1 0", out_valid, in_ready, frame_cnt);
        end
        push(8'h01, 1'b0); push(8'h09, 1'b0); push(8'h05, 1'b0); push(8'h07, 1'b0);
        pop(0);
    endtask

    task automatic test_full_frame();
        push(8'h12, 1'b0); push(8'hF0, 1'b0); push(8'h05, 1'b0); push(8'h80, 1'b0);
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL full_sort_cycle valid/ready=%b%b required 00", out_valid, in_ready); end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_max, out_second_max, out_second_min, out_min, out_count} !== {1'b1, 8'hF0, 8'h80, 8'h12, 8'h05, 3'd4}) begin
            errors++;
            $display("FAIL full_result valid=%b %h %h %h %h cnt %0d required 1 f0 80 12 05 cnt 4",
                     out_valid, out_max, out_second_max, out_second_min, out_min, out_count);
        end
        pop(0);
    endtask

    task automatic test_short_frame();
        push(8'h40, 1'b0); push(8'h90, 1'b1);
        @(posedge clk); #1;
        checks++;
        if ({out_max, out_second_max, out_second_min, out_min, out_count} !== {8'h90, 8'h40, 8'h00, 8'h00, 3'd2}) begin
            errors++;
            $display("FAIL short_result %h %h %h %h cnt %0d required 90 40 00 00 cnt 2",
                     out_max, out_second_max, out_second_min, out_min, out_count);
        end
        pop(0);
    endtask

    task automatic test_backpressure();
        logic [34:0] held;
        push(8'hA1, 1'b0); push(8'h3C, 1'b0); push(8'hD2, 1'b0); push(8'h07, 1'b0);
        @(posedge clk); #1;
        held = {out_max, out_second_max, out_second_min, out_min, out_count};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || {out_max, out_second_max, out_second_min, out_min, out_count} !== held) begin
                errors++; $display("FAIL bp_hold cycle %0d valid/ready=%b%b outputs %h required 10 %h", i, out_valid, in_ready,
                                   {out_max, out_second_max, out_second_min, out_min, out_count}, held);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        pop(0);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready=%b required 1", in_ready); end
        checks++;
        if ({out_max, out_second_max, out_second_min, out_min, out_count} !== held) begin
            errors++; $display("FAIL bp_after_hold outputs changed after transfer");
        end
    endtask

    task automatic test_duplicates();
        repeat (4) push(8'h77, 1'b0);
        pop(1);
        push(8'hAB, 1'b1);
        @(posedge clk); #1;
        checks++;
        if ({out_max, out_min, out_count} !== {8'hAB, 8'h00, 3'd1}) begin
            errors++; $display("FAIL dup_single max=%h min=%h cnt=%0d required ab 00 1", out_max, out_min, out_count);
        end
        pop(0);
    endtask

    task automatic test_wrap();
        logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(8'($urandom), 1'b1);
            pop(0);
            checks++;
            if (frame_cnt2 !== seq[i]) begin errors++; $display("FAIL wrap frame %0d cnt2=%0d required %0d", i, frame_cnt2, seq[i]); end
        end
    endtask

    task automatic test_random();
        int len;
        for (int f = 0; f < 40; f++) begin
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++)
                push((f % 5 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom), (i == len - 1) && (len < 4 || $urandom_range(0, 1) == 1));
            pop(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_full_frame();
        test_short_frame();
        test_backpressure();
        test_duplicates();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
